t02_fetch: RTL and testbench
============================

T02_FETCH -- requirements
Module: t02_fetch

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the first fetch address after reset.
REQ-002 SHALL have parameter NOP_INSTR, default 32'h0000_0013, meaning the word driven on instruction while instr_valid=0 (addi x0,x0,0).
REQ-003 SHALL have port clk  input  1  system clock, rising edge.
REQ-004 SHALL have port nRst  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port mem_req  output  1  instruction-memory read request.
REQ-006 SHALL have port mem_addr  output  32  word-aligned fetch address.
REQ-007 SHALL have port mem_ack  input  1  read complete; mem_rdata valid this cycle.
REQ-008 SHALL have port mem_rdata  input  32  fetched instruction word.
REQ-009 SHALL have port redirect_en  input  1  branch/jump taken, single-cycle pulse.
REQ-010 SHALL have port redirect_pc  input  32  redirect target.
REQ-011 SHALL have port stall  input  1  downstream not accepting the held instruction.
REQ-012 SHALL have port instruction  output  32  instruction word to the decode stage.
REQ-013 SHALL have port pc_out  output  32  address of instruction.
REQ-014 SHALL have port instr_valid  output  1  instruction/pc_out are valid.
REQ-015 SHALL have port fetch_err  output  1  misaligned-redirect flag (see Configuration).

Function
REQ-016 SHALL implement FSM states FETCH, VALID and FLUSH, with all state, pc, pc_out and the instruction register held in flops.
REQ-017 In FETCH, the block SHALL drive mem_req=1 and mem_addr=pc.
REQ-018 Memory protocol: mem_addr SHALL stay stable while mem_req=1 and until mem_ack, and mem_ack SHALL be honoured only while mem_req=1.
REQ-019 On FETCH with mem_ack=1 and no redirect, the block SHALL latch mem_rdata into instruction and pc into pc_out, set instr_valid, set pc<=pc+4, and go to VALID; minimum latency from request to instr_valid is 1 cycle after ack.
REQ-020 In VALID, the block SHALL drive mem_req=0; if stall=0 the instruction is consumed at that edge, so instr_valid<=0 and the FSM goes to FETCH; if stall=1 it SHALL hold all outputs.
REQ-021 A redirect in VALID SHALL clear instr_valid, set pc<=redirect target and go to FETCH; redirect has priority over stall.
REQ-022 A redirect in FETCH without mem_ack SHALL store the target and go to FLUSH, keeping mem_req=1 and the old mem_addr.
REQ-023 In FLUSH, the block SHALL keep the request active; on mem_ack it SHALL discard the data, set pc<=stored target and go to FETCH; a further redirect in FLUSH SHALL overwrite the stored target (last wins).
REQ-024 A redirect coinciding with mem_ack in FETCH SHALL discard the data, set pc<=target and stay in FETCH; instr_valid stays 0.
REQ-025 The redirect target SHALL always be used with bits [1:0] forced to 2'b00.
REQ-026 pc arithmetic SHALL be 32-bit modulo: 32'hFFFF_FFFC+4 SHALL give 32'h0000_0000.
REQ-027 While instr_valid=0, instruction SHALL equal NOP_INSTR and pc_out SHALL hold its last value.

Reset
REQ-028 On nRst=0 the block SHALL immediately set state=FETCH, pc=RESET_PC, pc_out=RESET_PC, instr_valid=0, the instruction register=NOP_INSTR, the stored target=0 and fetch_err=0.
REQ-029 Reset mid-transaction SHALL abandon any outstanding request; the first post-reset cycle SHALL drive mem_req=1 with mem_addr=RESET_PC.

Configuration
REQ-030 Macro T02_FETCH_ALIGN_CHECK_EN defined: when redirect_en=1 and redirect_pc[1:0]!=0, fetch_err SHALL be a registered one-cycle pulse on the following cycle; the redirect proceeds with bits forced per REQ-025.
REQ-031 Macro T02_FETCH_ALIGN_CHECK_EN undefined: fetch_err SHALL be constant 0 and no check logic SHALL be generated.

Verification
REQ-032 Reset release, mem_ack one cycle after each request with rdata=32'h0010_0093 -> mem_addr=0 then 4, instr_valid=1 with pc_out=0.
REQ-033 instr_valid=1 with stall=1 for 3 cycles -> instruction, pc_out and instr_valid stable and mem_req=0; after stall drops, next mem_addr=pc_out+4.
REQ-034 Redirect to 32'h0000_0100 in FETCH with ack delayed 2 cycles -> mem_addr stays old until ack, data discarded, then mem_addr=32'h100.
REQ-035 Redirect to 32'h0000_0200 coincident with mem_ack -> no instr_valid, next request at 32'h200; a redirect in VALID with stall=1 clears instr_valid.
REQ-036 RESET_PC=32'hFFFF_FFFC -> second fetch at 32'h0000_0000.
REQ-037 With T02_FETCH_ALIGN_CHECK_EN, redirect_pc=32'h0000_0102 -> fetch_err=1 for exactly one cycle and next mem_addr=32'h100; without the macro, fetch_err stays 0.

Source files
------------

// File: rtl/t02_fetch.sv
// t02_fetch: single-outstanding instruction fetch stage.
// Issues one word read at a time, holds the result for decode under stall, and
// handles branch redirects that arrive before, with, or after the memory ack.
// Optional build macro: T02_FETCH_ALIGN_CHECK_EN adds a registered one-cycle
// fetch_err pulse on a misaligned redirect target; without it fetch_err is 0.
module t02_fetch #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        nRst,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  input  logic        redirect_en,
  input  logic [31:0] redirect_pc,
  input  logic        stall,
  output logic [31:0] instruction,
  output logic [31:0] pc_out,
  output logic        instr_valid,
  output logic        fetch_err
);

  typedef enum logic [1:0] {StFetch, StValid, StFlush} state_e;

  state_e      state_q;
  logic [31:0] pc_q;
  logic [31:0] pc_out_q;
  logic [31:0] instr_q;
  logic [31:0] target_q;
  logic        valid_q;
  logic [31:0] redirect_tgt;

  // Targets are always word aligned; low bits are simply dropped.
  assign redirect_tgt = redirect_pc & 32'hFFFF_FFFC;

  // The request stays up in FLUSH so the address never changes before the ack.
  assign mem_req     = (state_q != StValid);
  assign mem_addr    = pc_q;
  assign instruction = instr_q;
  assign pc_out      = pc_out_q;
  assign instr_valid = valid_q;

  // Fetch FSM with registered pc, held instruction and flush target.
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      state_q  <= StFetch;
      pc_q     <= RESET_PC;
      pc_out_q <= RESET_PC;
      instr_q  <= NOP_INSTR;
      target_q <= 32'h0;
      valid_q  <= 1'b0;
    end else begin
      unique case (state_q)
        StFetch: begin
          if (redirect_en && mem_ack) begin
            // Data belongs to the wrong path; drop it and refetch at once.
            pc_q <= redirect_tgt;
          end else if (redirect_en) begin
            target_q <= redirect_tgt;
            state_q  <= StFlush;
          end else if (mem_ack) begin
            instr_q  <= mem_rdata;
            pc_out_q <= pc_q;
            valid_q  <= 1'b1;
            pc_q     <= pc_q + 32'd4;
            state_q  <= StValid;
          end
        end
        StValid: begin
          if (redirect_en) begin
            valid_q <= 1'b0;
            instr_q <= NOP_INSTR;
            pc_q    <= redirect_tgt;
            state_q <= StFetch;
          end else if (!stall) begin
            valid_q <= 1'b0;
            instr_q <= NOP_INSTR;
            state_q <= StFetch;
          end
        end
        StFlush: begin
          // A newer redirect replaces the pending target, even on the ack cycle.
          if (mem_ack) begin
            pc_q    <= redirect_en ? redirect_tgt : target_q;
            state_q <= StFetch;
          end else if (redirect_en) begin
            target_q <= redirect_tgt;
          end
        end
        default: state_q <= StFetch;
      endcase
    end
  end

`ifdef T02_FETCH_ALIGN_CHECK_EN
  logic err_q;

  // One-cycle flag for a redirect whose target had nonzero low bits.
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      err_q <= 1'b0;
    end else begin
      err_q <= redirect_en && (redirect_pc[1:0] != 2'b00);
    end
  end

  assign fetch_err = err_q;
`else
  assign fetch_err = 1'b0;
`endif

endmodule

// File: tb/tb_t02_fetch.sv
// Bench for t02_fetch: directed scenarios followed by random traffic, all
// compared cycle by cycle against a transaction-level model of the fetch stage.
module tb_t02_fetch;

`ifdef T02_FETCH_ALIGN_CHECK_EN
  localparam bit AlignEn = 1'b1;
`else
  localparam bit AlignEn = 1'b0;
`endif
  localparam logic [31:0] Nop = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        nRst;
  logic        mem_req, mem_ack, redirect_en, stall, instr_valid, fetch_err;
  logic [31:0] mem_addr, mem_rdata, redirect_pc, instruction, pc_out;

  // Second instance with a wrapping reset pc.
  logic        req2, ack2, valid2, err2;
  logic [31:0] addr2, instr2, pc_out2;

  always #5 clk = ~clk;

  t02_fetch #(.RESET_PC(32'h0000_0000), .NOP_INSTR(Nop)) dut (
    .clk(clk), .nRst(nRst), .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack),
    .mem_rdata(mem_rdata), .redirect_en(redirect_en), .redirect_pc(redirect_pc),
    .stall(stall), .instruction(instruction), .pc_out(pc_out), .instr_valid(instr_valid),
    .fetch_err(fetch_err)
  );

  t02_fetch #(.RESET_PC(32'hFFFF_FFFC), .NOP_INSTR(Nop)) dut2 (
    .clk(clk), .nRst(nRst), .mem_req(req2), .mem_addr(addr2), .mem_ack(ack2),
    .mem_rdata(32'hCAFE_0001), .redirect_en(1'b0), .redirect_pc(32'h0), .stall(1'b0),
    .instruction(instr2), .pc_out(pc_out2), .instr_valid(valid2), .fetch_err(err2)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Model: holding = an instruction is held for decode (no request outstanding);
  // discard = the outstanding read belongs to a squashed path.
  logic        m_holding, m_discard, m_err;
  logic [31:0] m_pc, m_tgt, m_instr, m_pc_out;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic model_reset();
    m_holding = 1'b0; m_discard = 1'b0; m_err = 1'b0;
    m_pc = 32'h0; m_tgt = 32'h0; m_instr = Nop; m_pc_out = 32'h0;
  endtask

  task automatic chk_all(input string tag);
    chk({tag, ".mem_req"}, {31'h0, mem_req}, {31'h0, !m_holding});
    chk({tag, ".mem_addr"}, mem_addr, m_pc);
    chk({tag, ".instr_valid"}, {31'h0, instr_valid}, {31'h0, m_holding});
    chk({tag, ".instruction"}, instruction, m_holding ? m_instr : Nop);
    chk({tag, ".pc_out"}, pc_out, m_pc_out);
    chk({tag, ".fetch_err"}, {31'h0, fetch_err}, {31'h0, m_err});
  endtask

  // Apply inputs for one cycle, advance the model at the edge, then compare.
  task automatic step(input string tag, input logic ren, input logic [31:0] rpc,
                      input logic ack, input logic [31:0] rd, input logic stl);
    logic [31:0] t;
    redirect_en = ren; redirect_pc = rpc; mem_ack = ack; mem_rdata = rd; stall = stl;
    @(posedge clk);
    t     = {rpc[31:2], 2'b00};
    m_err = AlignEn && ren && (rpc[1:0] != 2'b00);
    if (m_holding) begin
      if (ren) begin
        m_holding = 1'b0; m_pc = t;
      end else if (!stl) begin
        m_holding = 1'b0;
      end
    end else if (m_discard) begin
      if (ren) m_tgt = t;
      if (ack) begin
        m_discard = 1'b0; m_pc = m_tgt;
      end
    end else if (ren) begin
      if (ack) m_pc = t;
      else begin
        m_discard = 1'b1; m_tgt = t;
      end
    end else if (ack) begin
      m_holding = 1'b1; m_instr = rd; m_pc_out = m_pc; m_pc = m_pc + 32'd4;
    end
    #1;
    chk_all(tag);
  endtask

  initial begin
    redirect_en = 1'b0; redirect_pc = 32'h0; mem_ack = 1'b0; mem_rdata = 32'h0;
    stall = 1'b0; ack2 = 1'b0;
    nRst = 1'b0;
    model_reset();
    #12;
    chk_all("reset");
    nRst = 1'b1;
    #2;

    // Basic fetch and consume.
    step("req0", 0, 0, 0, 0, 0);
    chk("req0.addr", mem_addr, 32'h0);
    step("ack0", 0, 0, 1, 32'h0010_0093, 0);
    chk("ack0.pc_out", pc_out, 32'h0);
    chk("ack0.instr", instruction, 32'h0010_0093);
    step("cons0", 0, 0, 0, 0, 0);
    chk("cons0.addr", mem_addr, 32'h4);

    // Stall holds everything.
    step("ack1", 0, 0, 1, 32'h0010_0093, 0);
    for (int i = 0; i < 3; i++) step("stall", 0, 0, 0, 0, 1);
    step("unstall", 0, 0, 0, 0, 0);
    chk("unstall.addr", mem_addr, 32'h8);

    // Redirect in FETCH with late ack: address held, data discarded.
    step("rdf", 1, 32'h100, 0, 0, 0);
    chk("rdf.addr_hold", mem_addr, 32'h8);
    step("rdf.wait", 0, 0, 0, 0, 0);
    step("rdf.ack", 0, 0, 1, 32'hDEAD_BEEF, 0);
    chk("rdf.newaddr", mem_addr, 32'h100);

    // Redirect coincident with ack.
    step("rdack", 1, 32'h200, 1, 32'hDEAD_BEEF, 0);
    chk("rdack.addr", mem_addr, 32'h200);
    chk("rdack.valid", {31'h0, instr_valid}, 32'h0);

    // Redirect in VALID beats stall.
    step("v.ack", 0, 0, 1, 32'h1234_5678, 0);
    step("v.stall", 0, 0, 0, 0, 1);
    step("v.redir", 1, 32'h300, 0, 0, 1);
    chk("v.redir.valid", {31'h0, instr_valid}, 32'h0);
    chk("v.redir.addr", mem_addr, 32'h300);

    // Misaligned redirect.
    step("mis", 1, 32'h102, 0, 0, 0);
    chk("mis.err", {31'h0, fetch_err}, {31'h0, AlignEn});
    step("mis.after", 0, 0, 0, 0, 0);
    chk("mis.err_off", {31'h0, fetch_err}, 32'h0);
    step("mis.ack", 0, 0, 1, 32'h0, 0);
    chk("mis.addr", mem_addr, 32'h100);

    // Last redirect wins in FLUSH.
    step("lw1", 1, 32'h400, 0, 0, 0);
    step("lw2", 1, 32'h500, 0, 0, 0);
    step("lw.ack", 0, 0, 1, 32'h0, 0);
    chk("lw.addr", mem_addr, 32'h500);

    // Asynchronous reset mid-transaction.
    step("mr.ack", 0, 0, 1, 32'hABCD_0000, 0);
    step("mr.cons", 0, 0, 0, 0, 0);
    #2 nRst = 1'b0;
    #1;
    model_reset();
    chk_all("midreset");
    #2 nRst = 1'b1;

    // Wrapping reset pc on the second instance.
    @(posedge clk); #1;
    chk("wrap.addr0", addr2, 32'hFFFF_FFFC);
    ack2 = 1'b1;
    @(posedge clk); #1;
    ack2 = 1'b0;
    chk("wrap.valid", {31'h0, valid2}, 32'h1);
    chk("wrap.pc_out", pc_out2, 32'hFFFF_FFFC);
    @(posedge clk); #1;
    chk("wrap.req", {31'h0, req2}, 32'h1);
    chk("wrap.addr1", addr2, 32'h0);
    chk("wrap.err", {31'h0, err2}, 32'h0);
    chk("wrap.instr", instr2, Nop);

    // Random traffic; ack only offered while the model has a request open.
    step("rnd.sync", 0, 0, 0, 0, 0);
    for (int i = 0; i < 400; i++) begin
      logic        ren, ack, stl;
      logic [31:0] rpc;
      ren = ($urandom_range(0, 7) == 0);
      rpc = $urandom;
      ack = !m_holding && ($urandom_range(0, 1) == 1);
      stl = ($urandom_range(0, 1) == 1);
      step("rnd", ren, rpc, ack, $urandom, stl);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
